// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serdes_pkg
// Description : Shared types and helpers for the serializer/deserializer
//               family (PISO, SIPO, deserializer). Holds the two-state
//               shifter FSM encoding and the bit-counter width helper.
// Revision    : 1.0  initial release
// ============================================================================
package serdes_pkg;

  // Shifter state: waiting for a word, or presenting bits of a word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Width of a counter that must reach the value `width` (counts 1..width).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out stage. Accepts a WIDTH-bit word over a
//               valid/ready handshake and presents it one bit per enabled
//               clock on ser_out, with frame_start/frame_end markers.
//               Back-to-back words run with no gap bit.
// Ports       :
//   clk         in   rising-edge clock
//   clear       in   synchronous active-high reset
//   shift_en    in   advance one bit when high, hold everything when low
//   load_valid  in   load_data is valid
//   load_data   in   [WIDTH-1:0] parallel word to send
//   load_ready  out  word can be accepted this cycle (combinational)
//   ser_out     out  current serial bit (registered)
//   ser_valid   out  ser_out carries a frame bit (registered)
//   frame_start out  ser_out is the first bit of a word (registered)
//   frame_end   out  ser_out is the last bit of a word (registered)
//   busy        out  state is SHIFT
// Revision    : 1.0  initial release
// ============================================================================
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 4,     // legal range 2..32
  parameter bit MSB_FIRST = 1'b0   // 0: bit0 first, 1: bit WIDTH-1 first
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  ser_state_t       state,       state_n;
  logic [WIDTH-1:0] shreg,       shreg_n;
  logic [CNT_W-1:0] count,       count_n;
  logic             ser_out_n;
  logic             ser_valid_n;
  logic             frame_start_n;
  logic             frame_end_n;

  // Bit-order dependent taps. The shift register holds the bits not yet
  // presented, aligned so the next one always sits at the output end.
  logic             first_bit;   // bit presented on the capture edge
  logic [WIDTH-1:0] load_rest;   // remaining bits of the incoming word
  logic             next_bit;    // bit presented on the next enabled shift
  logic [WIDTH-1:0] shreg_adv;   // shift register after one shift

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit = load_data[WIDTH-1];
      assign load_rest = load_data << 1;
      assign next_bit  = shreg[WIDTH-1];
      assign shreg_adv = shreg << 1;
    end else begin : g_lsb_first
      assign first_bit = load_data[0];
      assign load_rest = load_data >> 1;
      assign next_bit  = shreg[0];
      assign shreg_adv = shreg >> 1;
    end
  endgenerate

  logic last_bit;
  assign last_bit = (count == CNT_LAST);

  // Ready on the edge that retires the last bit so the next word follows
  // without an idle cycle.
  assign load_ready = (state == IDLE) || (last_bit && shift_en);
  assign busy       = (state == SHIFT);

  always_comb begin
    state_n       = state;
    shreg_n       = shreg;
    count_n       = count;
    ser_out_n     = ser_out;
    ser_valid_n   = ser_valid;
    frame_start_n = frame_start;
    frame_end_n   = frame_end;

    unique case (state)
      IDLE: begin
        // Capture is not gated by shift_en: the first bit shows immediately.
        if (load_valid) begin
          state_n       = SHIFT;
          shreg_n       = load_rest;
          count_n       = CNT_ONE;
          ser_out_n     = first_bit;
          ser_valid_n   = 1'b1;
          frame_start_n = 1'b1;
          frame_end_n   = 1'b0;  // WIDTH >= 2, so bit 1 is never the last
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (last_bit) begin
            if (load_valid) begin
              shreg_n       = load_rest;
              count_n       = CNT_ONE;
              ser_out_n     = first_bit;
              ser_valid_n   = 1'b1;
              frame_start_n = 1'b1;
              frame_end_n   = 1'b0;
            end else begin
              state_n       = IDLE;
              shreg_n       = '0;
              count_n       = '0;
              ser_out_n     = 1'b0;
              ser_valid_n   = 1'b0;
              frame_start_n = 1'b0;
              frame_end_n   = 1'b0;
            end
          end else begin
            shreg_n       = shreg_adv;
            count_n       = count + CNT_ONE;
            ser_out_n     = next_bit;
            frame_start_n = 1'b0;
            frame_end_n   = ((count + CNT_ONE) == CNT_LAST);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      shreg       <= '0;
      count       <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      count       <= count_n;
      ser_out     <= ser_out_n;
      ser_valid   <= ser_valid_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed self-checking bench for piso_serializer. One LSB-first
//               and one MSB-first instance share the same stimulus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clear;
  logic       shift_en;
  logic       load_valid;
  logic [3:0] load_data;

  logic load_ready, ser_out, ser_valid, frame_start, frame_end, busy;
  logic m_load_ready, m_ser_out, m_ser_valid, m_frame_start, m_frame_end, m_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .clear(clear), .shift_en(shift_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clear(clear), .shift_en(shift_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(m_load_ready),
    .ser_out(m_ser_out), .ser_valid(m_ser_valid), .frame_start(m_frame_start),
    .frame_end(m_frame_end), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the registered frame outputs of the LSB-first instance.
  task automatic chk_bit(input string tag, input logic b, input logic fs, input logic fe);
    chk({tag, ".ser_out"},     ser_out,     b);
    chk({tag, ".ser_valid"},   ser_valid,   1'b1);
    chk({tag, ".frame_start"}, frame_start, fs);
    chk({tag, ".frame_end"},   frame_end,   fe);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ser_out"},     ser_out,     1'b0);
    chk({tag, ".ser_valid"},   ser_valid,   1'b0);
    chk({tag, ".frame_start"}, frame_start, 1'b0);
    chk({tag, ".frame_end"},   frame_end,   1'b0);
    chk({tag, ".busy"},        busy,        1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_bits;
    logic [3:0] sipo;

    // ---- Reset with a valid word offered: nothing may be captured
    clear      = 1'b1;
    shift_en   = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'hF;
    tick();
    tick();
    chk_idle("reset");
    chk("reset.load_ready", load_ready, 1'b1);
    chk("reset.msb_valid",  m_ser_valid, 1'b0);
    clear      = 1'b0;
    load_valid = 1'b0;
    tick();
    chk("reset.no_capture", busy, 1'b0);

    // ---- Single word 1011, LSB first -> 1,1,0,1 ; chained SIPO gets 1011
    load_data  = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = 4'h0;  // must not disturb the captured word
    exp_bits   = 4'b1011;
    sipo       = 4'h0;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("single[%0d]", i), exp_bits[i], i == 0, i == 3);
      sipo = {ser_out, sipo[3:1]};
      tick();
    end
    chk_idle("single.end");
    chk("single.sipo", sipo, 4'b1011);

    // ---- Back-to-back A then 5: 0,1,0,1,1,0,1,0 with no gap
    load_data  = 4'hA;
    load_valid = 1'b1;
    tick();
    load_data  = 4'h5;
    for (int i = 0; i < 8; i++) begin
      chk_bit($sformatf("b2b[%0d]", i), (i < 4) ? 1'(4'hA >> i) : 1'(4'h5 >> (i - 4)),
              (i == 0) || (i == 4), (i == 3) || (i == 7));
      if (i < 7) chk($sformatf("b2b[%0d].load_ready", i), load_ready, i == 3);
      tick();
      if (i == 3) load_valid = 1'b0;
    end
    chk_idle("b2b.end");

    // ---- Stall: 0110 -> 0,1,(hold 1 x3),1,0
    load_data  = 4'b0110;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_bit("stall.b1", 1'b0, 1'b1, 1'b0);
    tick();
    chk_bit("stall.b2", 1'b1, 1'b0, 1'b0);
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit($sformatf("stall.hold[%0d]", i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("stall.hold[%0d].load_ready", i), load_ready, 1'b0);
    end
    shift_en = 1'b1;
    tick();
    chk_bit("stall.b3", 1'b1, 1'b0, 1'b0);
    tick();
    chk_bit("stall.b4", 1'b0, 1'b0, 1'b1);
    tick();
    chk_idle("stall.end");

    // ---- Reset mid-frame after bit 2 of C, then load 3 -> 1,1,0,0
    load_data  = 4'hC;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    chk_bit("abort.b2", 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle("abort.cleared");
    load_data  = 4'h3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    exp_bits   = 4'h3;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("after_abort[%0d]", i), exp_bits[i], i == 0, i == 3);
      tick();
    end
    chk_idle("after_abort.end");

    // ---- MSB-first instance: 1000 -> 1,0,0,0
    load_data  = 4'b1000;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    exp_bits   = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("msb[%0d].ser_out", i),     m_ser_out,     exp_bits[3 - i]);
      chk($sformatf("msb[%0d].ser_valid", i),   m_ser_valid,   1'b1);
      chk($sformatf("msb[%0d].frame_start", i), m_frame_start, i == 0);
      chk($sformatf("msb[%0d].frame_end", i),   m_frame_end,   i == 3);
      tick();
    end
    chk("msb.end.ser_valid", m_ser_valid, 1'b0);
    chk("msb.end.busy",      m_busy,      1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
